// File: rtl/wb_slave_bridge.sv
// Wishbone slave bridge that turns single transfers into register or FIFO operations on a host-side handshake.
// Optional wait-state timeout is enabled by defining WB_SLAVE_BRIDGE_TIMEOUT_EN.
module wb_slave_bridge #(
    parameter int DATA_W   = 128,
    parameter int ADR_W    = 5,
    parameter int NUM_REGS = 16,
    parameter int FIFO_ADR = 16,
    parameter int CMD_ADR  = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              strobe,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              ack_o,
    output logic              error_o,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              cmd_done_i,
    input  logic              data_done_i,
    output logic [DATA_W-1:0] host_data_o,
    output logic              new_command,
    output logic              new_data,
    output logic              reg_read_en,
    output logic              reg_write_en,
    output logic              fifo_read_en,
    output logic              fifo_write_en
);

    typedef enum logic [2:0] {
        IDLE,
        REG_WAIT,
        FIFO_WAIT,
        ACK,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic        armed;
    logic        txn_we;
    logic [31:0] adr_ext;
    logic        is_reg;
    logic        is_fifo;
    logic        is_cmd;
    logic        accept;
    logic        timed_out;
    logic        rd_capture;

    logic              reg_write_en_nxt;
    logic              reg_read_en_nxt;
    logic              fifo_write_en_nxt;
    logic              fifo_read_en_nxt;
    logic              new_command_nxt;
    logic              new_data_nxt;
    logic              ack_nxt;
    logic              error_nxt;
    logic [DATA_W-1:0] host_data_nxt;
    logic [DATA_W-1:0] wb_data_nxt;

    assign adr_ext = 32'(adr_i);
    // Register window takes precedence should the FIFO address overlap it.
    assign is_reg  = adr_ext < 32'(NUM_REGS);
    assign is_fifo = !is_reg && (adr_ext == 32'(FIFO_ADR));
    assign is_cmd  = adr_ext == 32'(CMD_ADR);
    assign accept  = (state == IDLE) && strobe && armed;

`ifdef WB_SLAVE_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counter reads k in the k-th wait cycle after the enable pulse (which is cycle 0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == REG_WAIT || state == FIFO_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_reg)       state_next = REG_WAIT;
                    else if (is_fifo) state_next = FIFO_WAIT;
                    else              state_next = ERR;
                end
            end
            REG_WAIT: begin
                if (!strobe)         state_next = IDLE;
                else if (cmd_done_i) state_next = ACK;
                else if (timed_out)  state_next = ERR;
            end
            FIFO_WAIT: begin
                if (!strobe)          state_next = IDLE;
                else if (data_done_i) state_next = ACK;
                else if (timed_out)   state_next = ERR;
            end
            ACK:     state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        reg_write_en_nxt  = accept && is_reg && we_i;
        reg_read_en_nxt   = accept && is_reg && !we_i;
        fifo_write_en_nxt = accept && is_fifo && we_i;
        fifo_read_en_nxt  = accept && is_fifo && !we_i;
        new_command_nxt   = reg_write_en_nxt && is_cmd;
        new_data_nxt      = fifo_write_en_nxt;
        ack_nxt           = (state_next == ACK);
        error_nxt         = (state_next == ERR);

        host_data_nxt = host_data_o;
        if (accept && we_i) begin
            host_data_nxt = wb_data_i;
        end

        rd_capture = 1'b0;
        if (strobe && !txn_we) begin
            rd_capture = ((state == REG_WAIT) && cmd_done_i) ||
                         ((state == FIFO_WAIT) && data_done_i);
        end
        wb_data_nxt = rd_capture ? host_data_i : wb_data_o;
    end

    // Armed re-arms on any idle strobe sample so one held strobe yields only one transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed  <= 1'b1;
            txn_we <= 1'b0;
        end else begin
            if (!strobe)     armed <= 1'b1;
            else if (accept) armed <= 1'b0;
            if (accept)      txn_we <= we_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_en  <= 1'b0;
            reg_read_en   <= 1'b0;
            fifo_write_en <= 1'b0;
            fifo_read_en  <= 1'b0;
            new_command   <= 1'b0;
            new_data      <= 1'b0;
            ack_o         <= 1'b0;
            error_o       <= 1'b0;
            host_data_o   <= '0;
            wb_data_o     <= '0;
        end else begin
            reg_write_en  <= reg_write_en_nxt;
            reg_read_en   <= reg_read_en_nxt;
            fifo_write_en <= fifo_write_en_nxt;
            fifo_read_en  <= fifo_read_en_nxt;
            new_command   <= new_command_nxt;
            new_data      <= new_data_nxt;
            ack_o         <= ack_nxt;
            error_o       <= error_nxt;
            host_data_o   <= host_data_nxt;
            wb_data_o     <= wb_data_nxt;
        end
    end

endmodule
